// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first, repeating
// a latched number of frames with optional idle gap cycles between frames.
module seq_generator #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1011,
  parameter int               CNT_W    = 8,
  parameter int               GAP_W    = 4,
  parameter logic             IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             use_pat_in,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;

  // seq_valid marks every cycle whose seq_out is a pattern bit; there is no
  // back-pressure, so a receiver must consume the bit in the cycle it is valid.
  state_t             r_state, w_state;
  logic [PAT_W-1:0]   r_pat, w_pat;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [CNT_W-1:0]   r_frames, w_frames;
  logic [GAP_W-1:0]   r_gap_len, w_gap_len;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
  logic               r_out, w_out;
  logic               r_valid, w_valid;
  logic               r_fs, w_fs;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  logic [PAT_W-1:0]   w_sel_pat;
  logic [IDX_W-1:0]   w_idx_m1;
  logic [CNT_W-1:0]   w_frames_m1;

  assign w_sel_pat   = use_pat_in ? pat_in : PATTERN;
  assign w_idx_m1    = r_idx - 1'b1;
  assign w_frames_m1 = r_frames - 1'b1;

  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_idx     = r_idx;
    w_frames  = r_frames;
    w_gap_len = r_gap_len;
    w_gap_cnt = r_gap_cnt;
    w_out     = IDLE_BIT;
    w_valid   = 1'b0;
    w_fs      = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (repeat_cnt == '0) begin
            w_done = 1'b1;
          end else begin
            w_state   = S_SHIFT;
            w_pat     = w_sel_pat;
            w_frames  = repeat_cnt;
            w_gap_len = gap_cycles;
            w_idx     = IDX_MSB;
            w_out     = w_sel_pat[PAT_W-1];
            w_valid   = 1'b1;
            w_fs      = 1'b1;
            w_busy    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state   = S_IDLE;
          w_pat     = '0;
          w_idx     = '0;
          w_frames  = '0;
          w_gap_len = '0;
          w_gap_cnt = '0;
        end else if (r_idx != '0) begin
          w_idx   = w_idx_m1;
          w_out   = r_pat[w_idx_m1];
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end else begin
          // LSB just went out: this edge closes the frame
          w_frames = w_frames_m1;
          if (w_frames_m1 == '0) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else if (r_gap_len == '0) begin
            w_idx   = IDX_MSB;
            w_out   = r_pat[PAT_W-1];
            w_valid = 1'b1;
            w_fs    = 1'b1;
            w_busy  = 1'b1;
          end else begin
            w_state   = S_GAP;
            w_gap_cnt = r_gap_len - 1'b1;
            w_busy    = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state   = S_IDLE;
          w_pat     = '0;
          w_idx     = '0;
          w_frames  = '0;
          w_gap_len = '0;
          w_gap_cnt = '0;
        end else if (r_gap_cnt == '0) begin
          w_state = S_SHIFT;
          w_idx   = IDX_MSB;
          w_out   = r_pat[PAT_W-1];
          w_valid = 1'b1;
          w_fs    = 1'b1;
          w_busy  = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt - 1'b1;
          w_busy    = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_idx     <= '0;
      r_frames  <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_out     <= IDLE_BIT;
      r_valid   <= 1'b0;
      r_fs      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pat     <= w_pat;
      r_idx     <= w_idx;
      r_frames  <= w_frames;
      r_gap_len <= w_gap_len;
      r_gap_cnt <= w_gap_cnt;
      r_out     <= w_out;
      r_valid   <= w_valid;
      r_fs      <= w_fs;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign seq_out     = r_out;
  assign seq_valid   = r_valid;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: directed bursts plus random traffic, checked cycle by
// cycle against a queue of expected output cells built from the burst rules.
module tb_seq_generator;

  localparam int          PAT_W    = 4;
  localparam logic [3:0]  PATTERN  = 4'b1011;
  localparam int          CNT_W    = 8;
  localparam int          GAP_W    = 4;
  localparam logic        IDLE_BIT = 1'b0;
  // cell = {seq_out, seq_valid, frame_start, busy, done}
  localparam logic [4:0]  IDLE_CELL = {IDLE_BIT, 4'b0000};

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             use_pat_in;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_cycles;
  logic             seq_out;
  logic             seq_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  logic [4:0] exp_q[$];
  logic [4:0] m_cur;
  int         n_checks;
  int         n_pass;

  seq_generator #(
    .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .use_pat_in(use_pat_in), .pat_in(pat_in), .repeat_cnt(repeat_cnt),
    .gap_cycles(gap_cycles), .seq_out(seq_out), .seq_valid(seq_valid),
    .frame_start(frame_start), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Whole burst as seen on the outputs: N frames, gaps between them, then done.
  task automatic load_burst();
    logic [PAT_W-1:0] p;
    logic             fs;
    p = use_pat_in ? pat_in : PATTERN;
    for (int f = 0; f < int'(repeat_cnt); f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        fs = (b == PAT_W - 1);
        exp_q.push_back({p[b], 1'b1, fs, 1'b1, 1'b0});
      end
      if (f < int'(repeat_cnt) - 1)
        for (int g = 0; g < int'(gap_cycles); g++) exp_q.push_back({IDLE_BIT, 4'b0010});
    end
    exp_q.push_back({IDLE_BIT, 4'b0001});
  endtask

  task automatic step(input string tag);
    logic [4:0] obs;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_cur = IDLE_CELL;
    end else if (m_cur[1] && abort) begin
      exp_q.delete();
      m_cur = IDLE_CELL;
    end else begin
      if (exp_q.size() == 0 && start && !abort) load_burst();
      if (exp_q.size() > 0) m_cur = exp_q.pop_front();
      else m_cur = IDLE_CELL;
    end
    #1;
    obs = {seq_out, seq_valid, frame_start, busy, done};
    check(tag, 32'(obs), 32'(m_cur));
  endtask

  task automatic drain(input string tag);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 300 && (exp_q.size() > 0 || m_cur != IDLE_CELL); i++) step(tag);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int busy_len;
    n_checks = 0; n_pass = 0;
    m_cur = IDLE_CELL;
    reset = 1'b1; start = 1'b0; abort = 1'b0; use_pat_in = 1'b0;
    pat_in = '0; repeat_cnt = '0; gap_cycles = '0;
    step("reset"); step("reset");
    reset = 1'b0;
    step("post_reset"); step("post_reset");

    // Default pattern, single frame
    use_pat_in = 1'b0; repeat_cnt = 8'd1; gap_cycles = 4'd0; start = 1'b1;
    step("single");
    start = 1'b0;
    repeat (6) step("single");

    // Runtime pattern, three frames back-to-back
    use_pat_in = 1'b1; pat_in = 4'b1101; repeat_cnt = 8'd3; gap_cycles = 4'd0; start = 1'b1;
    step("rep3");
    start = 1'b0;
    repeat (14) step("rep3");

    // Two frames with a gap of 2; inputs change mid-burst; busy length is 10
    use_pat_in = 1'b0; repeat_cnt = 8'd2; gap_cycles = 4'd2; start = 1'b1;
    step("gap2");
    busy_len = busy ? 1 : 0;
    start = 1'b0; use_pat_in = 1'b1; pat_in = 4'b0110; repeat_cnt = 8'd7; gap_cycles = 4'd9;
    repeat (12) begin
      step("gap2");
      if (busy) busy_len++;
    end
    check("gap2_busy_len", 32'(busy_len), 32'd10);

    // Abort after two bits: no done afterwards
    use_pat_in = 1'b0; repeat_cnt = 8'd3; gap_cycles = 4'd1; start = 1'b1;
    step("abort"); start = 1'b0;
    step("abort");
    abort = 1'b1;
    step("abort");
    abort = 1'b0;
    repeat (3) step("abort_after");
    check("abort_no_done", 32'(done), 32'd0);

    // Start pulsed while busy is ignored
    repeat_cnt = 8'd2; gap_cycles = 4'd1; start = 1'b1;
    step("busy_start"); start = 1'b0;
    step("busy_start");
    start = 1'b1; repeat_cnt = 8'd5;
    repeat (3) step("busy_start");
    drain("busy_start");

    // Abort has priority over start in IDLE
    start = 1'b1; abort = 1'b1; repeat_cnt = 8'd1;
    step("abort_idle");
    start = 1'b0; abort = 1'b0;
    step("abort_idle");

    // repeat_cnt=0 pulses done only; start in the done cycle is accepted
    repeat_cnt = 8'd0; start = 1'b1;
    step("zero_rep");
    check("zero_rep_done", 32'(done), 32'd1);
    repeat_cnt = 8'd1;
    step("done_restart");
    check("done_restart_valid", 32'(seq_valid), 32'd1);
    start = 1'b0;
    drain("done_restart");

    // Asynchronous reset mid-burst clears outputs within the cycle
    use_pat_in = 1'b1; pat_in = 4'b1110; repeat_cnt = 8'd2; gap_cycles = 4'd0; start = 1'b1;
    step("mid_reset"); start = 1'b0;
    step("mid_reset");
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({seq_out, seq_valid, frame_start, busy, done}), 32'(IDLE_CELL));
    exp_q.delete();
    m_cur = IDLE_CELL;
    step("reset_hold");
    reset = 1'b0;
    step("reset_release");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 29) == 0);
      use_pat_in = 1'($urandom_range(0, 1));
      pat_in     = PAT_W'($urandom_range(0, 15));
      repeat_cnt = CNT_W'($urandom_range(0, 5));
      gap_cycles = GAP_W'($urandom_range(0, 4));
      step("rand");
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
Serial pattern transmitter that drives a single-bit stream into seq_detector-style receivers. On a start request it shifts out a PAT_W-bit pattern MSB-first, one bit per clock. The pattern comes from a parameter default or a runtime input, repeats a programmable number of frames, and can insert idle gap cycles between frames. It provides the stimulus side of the serial sequence interface, for both on-chip loopback and bench use.

Parameters:
PAT_W, 4, pattern length in bits (>=2).
PATTERN, 4'b1011, default pattern sent when use_pat_in=0.
CNT_W, 8, width of repeat_cnt (frame count).
GAP_W, 4, width of gap_cycles.
IDLE_BIT, 1'b0, value driven on seq_out when no frame bit is being sent.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request a burst; sampled only in IDLE.
abort  in  1  synchronous abort of the current burst.
use_pat_in  in  1  1: send pat_in; 0: send PATTERN; latched at start.
pat_in  in  PAT_W  runtime pattern, latched at start.
repeat_cnt  in  CNT_W  number of frames, latched at start.
gap_cycles  in  GAP_W  idle cycles between frames, latched at start.
seq_out  out  1  serial bit stream.
seq_valid  out  1  high while seq_out carries a pattern bit.
frame_start  out  1  high on the MSB cycle of each frame.
busy  out  1  high from the first bit through the last bit or gap cycle.
done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, immediate, also mid-burst):
  - State goes to IDLE.
  - seq_out=IDLE_BIT; seq_valid, frame_start, busy and done are all 0.
  - Internal pattern, bit-index, frame and gap counters are cleared.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, start=1 and repeat_cnt!=0 at an edge:
  - Latch the pattern, repeat_cnt and gap_cycles.
  - At that same edge: seq_out=pattern[PAT_W-1], seq_valid=1, frame_start=1, busy=1.
  - Go to SHIFT.
  - Latency: the first bit is visible in the cycle after the start edge.
- IDLE, start=1 and repeat_cnt==0:
  - No bits are sent and busy stays 0.
  - done pulses for one cycle.
- SHIFT:
  - Each edge advances the bit index (PAT_W-1 down to 0) and drives the next bit.
  - frame_start=0 after the MSB cycle.
  - After the LSB cycle, the frame counter decrements. Then:
    - Remaining frames==0: seq_out=IDLE_BIT, seq_valid=0, busy=0, done=1 for one cycle; go to IDLE.
    - Frames remain, gap==0: the next frame's MSB follows back-to-back, with frame_start=1.
    - Frames remain, gap>0: go to GAP.
- GAP:
  - seq_out=IDLE_BIT, seq_valid=0, busy=1 for exactly gap_cycles cycles.
  - Then the MSB of the next frame is driven with frame_start=1; go to SHIFT.
- abort=1 in SHIFT or GAP:
  - At the next edge, go to IDLE with outputs at their reset values.
  - done is NOT pulsed.
  - abort has priority over frame advance.
- abort in IDLE: no effect; abort has priority over start in the same cycle.
- start while busy=1: ignored; latched values are unaffected by input changes mid-burst.
- start during the done cycle: the FSM is already in IDLE, so start is accepted. The first bit appears next cycle, giving back-to-back bursts with one idle cycle between.
- Counters:
  - Bit index is $clog2(PAT_W) bits wide.
  - Frame counter is CNT_W bits, so up to 2^CNT_W-1 frames; no wrap.
  - Gap counter is GAP_W bits.
- Burst length: busy is high for N*PAT_W + (N-1)*gap cycles, where N=repeat_cnt.

Test Plan:
- Reset -> after reset deasserts with start=0: seq_out=0, seq_valid/busy/done/frame_start=0; assert reset mid-burst -> all outputs clear within the same cycle.
- use_pat_in=0, repeat_cnt=1, gap_cycles=0, pulse start -> seq_out=1,0,1,1 on 4 consecutive cycles with seq_valid=1; frame_start on the first bit only; busy for 4 cycles; done=1 for 1 cycle right after; a downstream seq_detector for 1011 fires once.
- use_pat_in=1, pat_in=4'b1101, repeat_cnt=3, gap_cycles=0 -> 12 bits 1101_1101_1101; frame_start at bit offsets 0, 4 and 8; done after bit 12.
- repeat_cnt=2, gap_cycles=2, PATTERN -> 1011, then 0,0 with seq_valid=0, then 1011; busy=10 cycles; a pat_in/repeat_cnt change mid-burst has no effect.
- Abort and ignored start: start burst, abort after 2 bits -> next cycle IDLE, seq_valid=0, no done; start pulsed while busy -> ignored.
- repeat_cnt=0 with start -> no seq_valid, busy stays 0, done pulses 1 cycle; start asserted in the done cycle -> new burst begins on the next cycle.
